// File: rtl/keypad_entry_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_entry_ctrl_if
// Description : Bundle of keypad data, debounced key events and the committed
//               entry handshake between keypad_entry_ctrl and its environment.
//               master = environment (scanner + application side),
//               slave  = keypad_entry_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_entry_ctrl_if #(
    parameter int MAX_DIGITS = 4
);
    logic [11:0]             key_data;
    logic                    entry_ack;
    logic                    key_evt;
    logic [3:0]              key_code;
    logic [4*MAX_DIGITS-1:0] entry_digits;
    logic [3:0]              entry_cnt;
    logic                    entry_valid;
    logic                    overflow;
    logic                    timeout;

    modport master (
        output key_data,
        output entry_ack,
        input  key_evt,
        input  key_code,
        input  entry_digits,
        input  entry_cnt,
        input  entry_valid,
        input  overflow,
        input  timeout
    );

    modport slave (
        input  key_data,
        input  entry_ack,
        output key_evt,
        output key_code,
        output entry_digits,
        output entry_cnt,
        output entry_valid,
        output overflow,
        output timeout
    );
endinterface
`default_nettype wire

// File: rtl/keypad_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : keypad_entry_ctrl
// Description : Debounces the one-hot 4x3 keypad vector into single key events
//               and assembles them into a BCD entry ('*' clears, '#' commits).
//               Committed entries are held until acknowledged.
//               Optional idle timeout: define KEYPAD_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_entry_ctrl #(
    parameter logic [15:0] DEB_CYCLES     = 16'd50000,
    parameter int          MAX_DIGITS     = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd250000000
) (
    input wire logic           clk,
    input wire logic           rst,
    keypad_entry_ctrl_if.slave bus
);
    localparam logic [3:0] c_max_digits = 4'(MAX_DIGITS);
    localparam logic [3:0] c_code_star  = 4'hA;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DEB  = 2'd1,
        S_HELD = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nx;
    logic [11:0]             r_sample;
    logic [15:0]             r_dcnt;
    logic [15:0]             w_dcnt_nx;
    logic [15:0]             w_dcnt_inc;
    logic [3:0]              r_cand;
    logic [3:0]              w_cand_nx;
    logic                    w_dec_valid;
    logic [3:0]              w_dec_code;
    logic                    w_accept;
    logic [3:0]              w_acc_code;
    logic                    r_key_evt;
    logic [3:0]              r_key_code;
    logic [4*MAX_DIGITS-1:0] r_digits;
    logic [4*MAX_DIGITS-1:0] w_shifted;
    logic [3:0]              r_cnt;
    logic                    r_valid;
    logic                    r_overflow;
    logic                    w_timeout_hit;

    // Single sample register between the scanner and the decoder
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sample <= '0;
        else     r_sample <= bus.key_data;
    end

    // One-hot to key code; anything not exactly one-hot is NONE
    always_comb begin
        w_dec_valid = 1'b1;
        w_dec_code  = 4'd0;
        case (r_sample)
            12'h001: w_dec_code = 4'd1;
            12'h002: w_dec_code = 4'd2;
            12'h004: w_dec_code = 4'd3;
            12'h008: w_dec_code = 4'd4;
            12'h010: w_dec_code = 4'd5;
            12'h020: w_dec_code = 4'd6;
            12'h040: w_dec_code = 4'd7;
            12'h080: w_dec_code = 4'd8;
            12'h100: w_dec_code = 4'd9;
            12'h200: w_dec_code = 4'hA;
            12'h400: w_dec_code = 4'd0;
            12'h800: w_dec_code = 4'hB;
            default: w_dec_valid = 1'b0;
        endcase
    end

    assign w_dcnt_inc = r_dcnt + 16'd1;

    // Debounce state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_dcnt  <= '0;
            r_cand  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_dcnt  <= w_dcnt_nx;
            r_cand  <= w_cand_nx;
        end
    end

    // Debounce next-state: press needs DEB_CYCLES matching samples, release
    // needs DEB_CYCLES NONE samples; a held or changed key never re-fires
    always_comb begin
        w_state_nx = r_state;
        w_dcnt_nx  = r_dcnt;
        w_cand_nx  = r_cand;
        w_accept   = 1'b0;
        w_acc_code = r_cand;
        case (r_state)
            S_IDLE: begin
                if (w_dec_valid) begin
                    w_cand_nx = w_dec_code;
                    if (DEB_CYCLES == 16'd1) begin
                        // The first sample already satisfies a one-sample debounce
                        w_accept   = 1'b1;
                        w_acc_code = w_dec_code;
                        w_state_nx = S_HELD;
                        w_dcnt_nx  = '0;
                    end else begin
                        w_state_nx = S_DEB;
                        w_dcnt_nx  = 16'd1;
                    end
                end
            end
            S_DEB: begin
                if (w_dec_valid && (w_dec_code == r_cand)) begin
                    if (w_dcnt_inc == DEB_CYCLES) begin
                        w_accept   = 1'b1;
                        w_state_nx = S_HELD;
                        w_dcnt_nx  = '0;
                    end else begin
                        w_dcnt_nx = w_dcnt_inc;
                    end
                end else begin
                    w_state_nx = S_IDLE;
                    w_dcnt_nx  = '0;
                end
            end
            S_HELD: begin
                if (!w_dec_valid) begin
                    if (w_dcnt_inc == DEB_CYCLES) begin
                        w_state_nx = S_IDLE;
                        w_dcnt_nx  = '0;
                    end else begin
                        w_dcnt_nx = w_dcnt_inc;
                    end
                end else begin
                    w_dcnt_nx = '0;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_dcnt_nx  = '0;
            end
        endcase
    end

    // Digit append; a single-digit entry simply replaces its only digit
    generate
        if (MAX_DIGITS == 1) begin : g_shift_single
            assign w_shifted = w_acc_code;
        end else begin : g_shift_multi
            assign w_shifted = {r_digits[4*MAX_DIGITS-5:0], w_acc_code};
        end
    endgenerate

    // Key event pulse and last accepted code
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_evt  <= 1'b0;
            r_key_code <= '0;
        end else begin
            r_key_evt <= w_accept;
            if (w_accept) r_key_code <= w_acc_code;
        end
    end

    // Entry assembly; a pending commit blocks all actions until acknowledged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digits   <= '0;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            if (r_valid) begin
                if (bus.entry_ack) begin
                    r_valid  <= 1'b0;
                    r_digits <= '0;
                    r_cnt    <= '0;
                end
            end else if (w_accept) begin
                if (w_acc_code <= 4'd9) begin
                    if (r_cnt < c_max_digits) begin
                        r_digits <= w_shifted;
                        r_cnt    <= r_cnt + 4'd1;
                    end else begin
                        r_overflow <= 1'b1;
                    end
                end else if (w_acc_code == c_code_star) begin
                    r_digits <= '0;
                    r_cnt    <= '0;
                end else if (r_cnt != 4'd0) begin
                    r_valid <= 1'b1;
                end
            end else if (w_timeout_hit) begin
                r_digits <= '0;
                r_cnt    <= '0;
            end
        end
    end

`ifdef KEYPAD_TIMEOUT_EN
    logic [31:0] r_idle_cnt;
    logic [31:0] w_idle_inc;
    logic        w_idle_run;
    logic        r_timeout;

    assign w_idle_run    = (r_cnt != 4'd0) && !r_valid;
    assign w_idle_inc    = r_idle_cnt + 32'd1;
    assign w_timeout_hit = w_idle_run && !w_accept && (w_idle_inc == TIMEOUT_CYCLES);

    // Idle counter for a partial entry; any accepted key restarts it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_timeout_hit;
            if (w_accept || !w_idle_run || w_timeout_hit) r_idle_cnt <= '0;
            else                                          r_idle_cnt <= w_idle_inc;
        end
    end

    assign bus.timeout = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign bus.timeout   = 1'b0;
`endif

    assign bus.key_evt      = r_key_evt;
    assign bus.key_code     = r_key_code;
    assign bus.entry_digits = r_digits;
    assign bus.entry_cnt    = r_cnt;
    assign bus.entry_valid  = r_valid;
    assign bus.overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_entry_ctrl
// Description : Self-checking bench for keypad_entry_ctrl. Expected key events
//               are queued when a press is driven and compared when the DUT
//               pulses key_evt.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_entry_ctrl;
    localparam int c_deb = 4;

    typedef struct packed {
        logic [3:0]  code;
        logic [15:0] digits;
        logic [3:0]  cnt;
        logic        valid;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst;
    keypad_entry_ctrl_if #(.MAX_DIGITS(4)) bus();

    keypad_entry_ctrl #(
        .DEB_CYCLES    (16'd4),
        .MAX_DIGITS    (4),
        .TIMEOUT_CYCLES(32'd100)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_evt_cyc = 0;
    int          drive_cyc = 0;
    logic        to_seen = 1'b0;
    exp_t        exp_q[$];
    logic [15:0] m_digits = '0;
    logic [3:0]  m_cnt = '0;
    logic        m_valid = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] bit2code(input int b);
        if (b < 9)       return 4'(b + 1);
        else if (b == 9) return 4'hA;
        else if (b == 10) return 4'd0;
        else             return 4'hB;
    endfunction

    // Event scoreboard consumer
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.key_evt) begin
                last_evt_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_evt", 32'(bus.key_evt), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("evt_code",   32'(bus.key_code),     32'(e.code));
                    chk("evt_digits", 32'(bus.entry_digits), 32'(e.digits));
                    chk("evt_cnt",    32'(bus.entry_cnt),    32'(e.cnt));
                    chk("evt_valid",  32'(bus.entry_valid),  32'(e.valid));
                    chk("evt_ovf",    32'(bus.overflow),     32'(e.ovf));
                end
            end else if (bus.overflow) begin
                chk("ovf_without_evt", 32'(bus.overflow), 32'd0);
            end
            if (bus.timeout) begin
`ifdef KEYPAD_TIMEOUT_EN
                to_seen = 1'b1;
`else
                chk("timeout_disabled", 32'(bus.timeout), 32'd0);
`endif
            end
        end
    end

    // Drive one key: model the entry action, queue the expectation, then
    // hold the key and release it
    task automatic press(input int b, input int hold, input int rel);
        exp_t       e;
        logic [3:0] c;
        c     = bit2code(b);
        e.ovf = 1'b0;
        if (!m_valid) begin
            if (c <= 4'd9) begin
                if (m_cnt < 4'd4) begin
                    m_digits = {m_digits[11:0], c};
                    m_cnt    = m_cnt + 4'd1;
                end else begin
                    e.ovf = 1'b1;
                end
            end else if (c == 4'hA) begin
                m_digits = '0;
                m_cnt    = '0;
            end else if (m_cnt != 4'd0) begin
                m_valid = 1'b1;
            end
        end
        e.code   = c;
        e.digits = m_digits;
        e.cnt    = m_cnt;
        e.valid  = m_valid;
        exp_q.push_back(e);
        @(posedge clk); #1;
        drive_cyc    = cyc;
        bus.key_data = 12'(1) << b;
        repeat (hold) @(posedge clk);
        #1 bus.key_data = '0;
        repeat (rel) @(posedge clk);
        #1;
    endtask

    task automatic do_ack();
        @(posedge clk); #1 bus.entry_ack = 1'b1;
        @(posedge clk); #1 bus.entry_ack = 1'b0;
        if (m_valid) begin
            m_valid  = 1'b0;
            m_digits = '0;
            m_cnt    = '0;
        end
    endtask

    task automatic chk_entry(input string tag, input logic [15:0] d, input logic [3:0] n, input logic v);
        chk({tag, "_digits"}, 32'(bus.entry_digits), 32'(d));
        chk({tag, "_cnt"},    32'(bus.entry_cnt),    32'(n));
        chk({tag, "_valid"},  32'(bus.entry_valid),  32'(v));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.key_data  = '0;
        bus.entry_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_key_evt",  32'(bus.key_evt),  32'd0);
        chk("rst_key_code", 32'(bus.key_code), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_timeout",  32'(bus.timeout),  32'd0);
        chk_entry("rst", 16'h0000, 4'd0, 1'b0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single press of '5', including press latency
        press(4, 10, 10);
        chk("press_latency", 32'(last_evt_cyc - drive_cyc), 32'(c_deb + 1));
        chk_entry("p5", 16'h0005, 4'd1, 1'b0);

        // Short glitch and two-key bounce must not produce events
        @(posedge clk); #1 bus.key_data = 12'h010;
        repeat (3) @(posedge clk);
        #1 bus.key_data = '0;
        repeat (10) @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            #1 bus.key_data = (i % 2 == 0) ? 12'h002 : 12'h004;
            @(posedge clk);
        end
        #1 bus.key_data = '0;
        repeat (10) @(posedge clk);
        #1;
        chk_entry("noise", 16'h0005, 4'd1, 1'b0);

        // Clear, then 1..5 with overflow on the fifth, commit, locked '7'
        press(9, 8, 8);
        for (int b = 0; b < 5; b++) press(b, 8, 8);
        press(11, 8, 8);
        chk_entry("commit", 16'h1234, 4'd4, 1'b1);
        press(6, 8, 8);
        chk_entry("locked", 16'h1234, 4'd4, 1'b1);
        do_ack();
        chk_entry("ack", 16'h0000, 4'd0, 1'b0);

        // 9, '*', 0, '#'
        press(8, 8, 8);
        press(9, 8, 8);
        press(10, 8, 8);
        press(11, 8, 8);
        chk_entry("zero", 16'h0000, 4'd1, 1'b1);
        do_ack();
        press(11, 8, 8);
        chk_entry("empty_hash", 16'h0000, 4'd0, 1'b0);

        // Ack without a pending entry is ignored
        press(2, 8, 8);
        do_ack();
        chk_entry("stray_ack", 16'h0003, 4'd1, 1'b0);

        // Idle behaviour of a partial entry
        press(7, 8, 8);
`ifdef KEYPAD_TIMEOUT_EN
        for (int i = 0; i < 200 && !to_seen; i++) @(posedge clk);
        #1;
        chk("timeout_seen", 32'(to_seen), 32'd1);
        m_digits = '0;
        m_cnt    = '0;
        chk_entry("timeout", 16'h0000, 4'd0, 1'b0);
        press(7, 8, 8);
`else
        repeat (150) @(posedge clk);
        #1;
        chk_entry("idle_hold", 16'h0038, 4'd2, 1'b0);
`endif

        // Reset while a key is in debounce
        @(posedge clk); #1 bus.key_data = 12'h004;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_key_evt",  32'(bus.key_evt),  32'd0);
        chk("mid_rst_key_code", 32'(bus.key_code), 32'd0);
        chk_entry("mid_rst", 16'h0000, 4'd0, 1'b0);
        repeat (6) @(posedge clk);
        #1 bus.key_data = '0;
        m_digits = '0;
        m_cnt    = '0;
        m_valid  = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_key_evt", 32'(bus.key_evt), 32'd0);
        chk_entry("post_rst", 16'h0000, 4'd0, 1'b0);

        chk("pending_evts", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
